switch_arbiter_6line: RTL and testbench

Output-port switch allocator for the virtual-channel router. It arbitrates six input-VC requesters for one output link and drives the one-hot 6-bit select of that port's 32-bit output bus mux. Each granted packet holds the link from head to tail, with credit-based flow control toward the downstream buffer. When no input is granted, the select is all-zero and the mux emits the idle flit 32'h6000_0000.

---
 rtl/router_pkg.sv | 38 +++
 rtl/rr_pick6.sv | 32 +++
 rtl/switch_arbiter_6line.sv | 114 +++++++++++
 tb/tb_switch_arbiter_6line.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: port count, idle flit, flit type codes,
// one-hot port constants and credit sizing for the switch arbiter.
package router_pkg;

   localparam int N_PORTS = 6;
   localparam int CREDITS = 4;
   localparam int CNT_W   = 3;

   localparam logic [31:0] IDLE_FLIT = 32'h6000_0000;

   // Flit type lives in bits [31:30]; the idle flit decodes as FT_IDLE.
   typedef enum logic [1:0] {
      FT_BODY = 2'b00,
      FT_IDLE = 2'b01,
      FT_HEAD = 2'b10,
      FT_TAIL = 2'b11
   } flit_type_e;

   localparam logic [5:0] PORT0 = 6'b000001;
   localparam logic [5:0] PORT1 = 6'b000010;
   localparam logic [5:0] PORT2 = 6'b000100;
   localparam logic [5:0] PORT3 = 6'b001000;
   localparam logic [5:0] PORT4 = 6'b010000;
   localparam logic [5:0] PORT5 = 6'b100000;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } arb_state_e;

   function automatic logic [2:0] oh_idx(input logic [5:0] oh);
      oh_idx = '0;
      for (int i = 0; i < 6; i++) begin
         if (oh[i]) oh_idx = 3'(i);
      end
   endfunction

endpackage

// File: rtl/rr_pick6.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping 5 -> 0, returned one-hot with a valid flag.
module rr_pick6
   import router_pkg::*;
(
   input  logic [5:0] req,
   input  logic [2:0] ptr,
   output logic [5:0] pick,
   output logic       valid
);

   logic [3:0] j;
   logic       found;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      j     = '0;
      for (int k = 0; k < 6; k++) begin
         j = {1'b0, ptr} + 4'(k);
         if (j >= 4'd6) j = j - 4'd6;
         if (j >= 4'd6) j = j - 4'd6;
         if (!found && req[j[2:0]]) begin
            pick[j[2:0]] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/switch_arbiter_6line.sv
// Output-port switch allocator: round-robin, packet-locked, one-hot grant.
// Credit flow control is built only when SWARB_CREDIT_EN is defined.
module switch_arbiter_6line
   import router_pkg::*;
#(
   parameter int N_IN = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_IN-1:0] req,
   input  logic [N_IN-1:0] tail,
`ifdef SWARB_CREDIT_EN
   input  logic            credit_in,
   output logic [CNT_W-1:0] credit_cnt,
`endif
   output logic [N_IN-1:0] grant,
   output logic            credit_err
);

   arb_state_e      state_q, state_d;
   logic [2:0]      lock_q, lock_d;
   logic [2:0]      ptr_q, ptr_d;
   logic [N_IN-1:0] grant_q, grant_d;
   logic [N_IN-1:0] lock_oh;
   logic [N_IN-1:0] pick;
   logic            pick_vld;
   logic            xfer;
   logic            tail_xfer;
   logic            release_w;
   logic            avail;

   assign xfer      = |(grant_q & req);
   assign tail_xfer = |(grant_q & req & tail);
   assign release_w = (state_q == ST_LOCKED) && tail_xfer;
   assign lock_oh   = N_IN'(1) << lock_q;

   // Releasing input moves to lowest priority for the same-cycle re-pick.
   assign ptr_d = release_w ? ((lock_q == 3'd5) ? 3'd0 : lock_q + 3'd1)
                            : ptr_q;

`ifdef SWARB_CREDIT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (credit_in && !xfer) begin
         if (cnt_q == CNT_W'(CREDITS)) err_d = 1'b1;
         else                          cnt_d = cnt_q + 1'b1;
      end else if (xfer && !credit_in && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign avail = (cnt_d != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= CNT_W'(CREDITS);
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign credit_cnt = cnt_q;
   assign credit_err = err_q;
`else
   assign avail      = 1'b1;
   assign credit_err = 1'b0;
`endif

   rr_pick6 u_pick (
      .req   (req),
      .ptr   (ptr_d),
      .pick  (pick),
      .valid (pick_vld)
   );

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      grant_d = '0;
      if (state_q == ST_IDLE || release_w) begin
         state_d = ST_IDLE;
         if (avail && pick_vld) begin
            state_d = ST_LOCKED;
            lock_d  = oh_idx(pick);
            grant_d = pick;
         end
      end else begin
         grant_d = lock_oh & req & {N_IN{avail}};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         lock_q  <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
      end
   end

   assign grant = grant_q;

endmodule

// File: tb/tb_switch_arbiter_6line.sv
// Bench for switch_arbiter_6line: packet-level model compared every cycle,
// plus directed scenarios with hand-derived grant/credit expectations.
module tb_switch_arbiter_6line;
   import router_pkg::*;

`ifdef SWARB_CREDIT_EN
   localparam bit CREDIT_EN = 1'b1;
`else
   localparam bit CREDIT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] req;
   logic [5:0] tail;
   logic       credit_in;
   logic [5:0] grant;
   logic       credit_err;
`ifdef SWARB_CREDIT_EN
   logic [CNT_W-1:0] credit_cnt;
`endif

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   int m_owner = -1;
   int m_ptr   = 0;
   int m_cr    = CREDITS;
   int m_g     = -1;
   bit m_err   = 1'b0;

   always #5 clk = ~clk;

   switch_arbiter_6line dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .tail       (tail),
`ifdef SWARB_CREDIT_EN
      .credit_in  (credit_in),
      .credit_cnt (credit_cnt),
`endif
      .grant      (grant),
      .credit_err (credit_err)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Packet-level model: owner, round-robin pointer, credit count.
   always @(posedge clk) begin : mdl
      int o, p, c, g;
      bit e, xf, av, cin;
      o = m_owner; p = m_ptr; c = m_cr; g = m_g; e = m_err;
      if (reset) begin
         o = -1; p = 0; c = CREDITS; g = -1; e = 1'b0;
      end else begin
         cin = CREDIT_EN && credit_in;
         xf  = (g >= 0) && req[g];
         if (cin && !xf) begin
            if (c == CREDITS) e = 1'b1;
            else c = c + 1;
         end else if (xf && !cin) begin
            c = c - 1;
         end
         av = !CREDIT_EN || (c > 0);
         if (xf && tail[g]) begin
            p = (g + 1) % 6;
            o = -1;
         end
         if (o < 0) begin
            g = -1;
            if (av) begin
               for (int k = 0; k < 6; k++) begin
                  if (g < 0 && req[(p + k) % 6]) begin
                     g = (p + k) % 6;
                     o = g;
                  end
               end
            end
         end else begin
            g = (req[o] && av) ? o : -1;
         end
      end
      m_owner <= o; m_ptr <= p; m_cr <= c; m_g <= g; m_err <= e;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("grant_model", 32'(grant),
             (m_g < 0) ? 32'd0 : (32'd1 << m_g));
         chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
`ifdef SWARB_CREDIT_EN
         chk("cnt_model", 32'(credit_cnt), 32'(m_cr));
         chk("err_model", 32'(credit_err), 32'(m_err));
`else
         chk("err_tied", 32'(credit_err), 32'd0);
`endif
      end
   end

   task automatic cyc(input logic [5:0] r, input logic [5:0] t,
                      input logic c, input logic rs);
      req = r; tail = t; credit_in = c; reset = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; req = '0; tail = '0; credit_in = 1'b0;
      cyc(6'h00, 6'h00, 1'b0, 1'b1);
      chk_en = 1'b1;
      cyc(6'h00, 6'h00, 1'b0, 1'b1);
      chk("rst_grant", 32'(grant), 32'h0);
`ifdef SWARB_CREDIT_EN
      chk("rst_cnt", 32'(credit_cnt), 32'd4);
`endif
      chk("rst_err", 32'(credit_err), 32'd0);

      // Back-to-back packets: 3-flit packet on 0, then 2 with no bubble.
      cyc(6'b000101, 6'b000000, 1'b0, 1'b0);
      chk("b2b_t1", 32'(grant), 32'h01);
      cyc(6'b000101, 6'b000000, 1'b0, 1'b0);
      chk("b2b_t2", 32'(grant), 32'h01);
      cyc(6'b000101, 6'b000000, 1'b1, 1'b0);
      chk("b2b_t3", 32'(grant), 32'h01);
      cyc(6'b000101, 6'b000001, 1'b1, 1'b0);
      chk("b2b_t4", 32'(grant), 32'h04);
      cyc(6'b000100, 6'b000100, 1'b1, 1'b0);
      cyc(6'h00, 6'h00, 1'b0, 1'b1);

      // All requesters, single-flit packets, credit returned each transfer.
      for (int k = 0; k < 7; k++) begin
         cyc(6'h3f, 6'h3f, k > 0, 1'b0);
         chk("rr_seq", 32'(grant), 32'd1 << (k % 6));
      end
      cyc(6'h00, 6'h00, 1'b0, 1'b1);

`ifdef SWARB_CREDIT_EN
      // Credit exhaustion on a long packet, then resume on credit_in.
      for (int k = 0; k < 7; k++) begin
         cyc(6'h01, 6'h00, 1'b0, 1'b0);
         chk("cred_hold", 32'(grant), (k < 4) ? 32'h01 : 32'h00);
      end
      chk("cred_zero", 32'(credit_cnt), 32'd0);
      cyc(6'h01, 6'h00, 1'b1, 1'b0);
      chk("cred_resume", 32'(grant), 32'h01);
`else
      for (int k = 0; k < 7; k++) begin
         cyc(6'h01, (k == 5) ? 6'h01 : 6'h00, 1'b0, 1'b0);
         chk("nocred_hold", 32'(grant), 32'h01);
      end
`endif
      cyc(6'h00, 6'h00, 1'b0, 1'b1);

      // Locked on 3 with a mid-packet req gap while input 0 waits.
      cyc(6'b001000, 6'h00, 1'b0, 1'b0);
      chk("lk_t1", 32'(grant), 32'h08);
      cyc(6'b001001, 6'h00, 1'b0, 1'b0);
      chk("lk_t2", 32'(grant), 32'h08);
      cyc(6'b000001, 6'h00, 1'b0, 1'b0);
      chk("lk_bub1", 32'(grant), 32'h00);
      cyc(6'b000001, 6'h00, 1'b0, 1'b0);
      chk("lk_bub2", 32'(grant), 32'h00);
      cyc(6'b001001, 6'h00, 1'b0, 1'b0);
      chk("lk_resume", 32'(grant), 32'h08);
      cyc(6'b001001, 6'b001000, 1'b0, 1'b0);
      chk("lk_next0", 32'(grant), 32'h01);
      cyc(6'h00, 6'h00, 1'b0, 1'b1);

      // Reset while locked on input 2.
      for (int k = 0; k < 4; k++) cyc(6'b000100, 6'h00, 1'b0, 1'b0);
      chk("rl_grant", 32'(grant), 32'h04);
`ifdef SWARB_CREDIT_EN
      chk("rl_cnt", 32'(credit_cnt), 32'd1);
`endif
      cyc(6'b000100, 6'h00, 1'b0, 1'b1);
      chk("rl_rst_grant", 32'(grant), 32'h00);
`ifdef SWARB_CREDIT_EN
      chk("rl_rst_cnt", 32'(credit_cnt), 32'd4);

      // Credit overflow at full count is sticky until reset.
      cyc(6'h00, 6'h00, 1'b1, 1'b0);
      chk("ovf_cnt", 32'(credit_cnt), 32'd4);
      chk("ovf_err", 32'(credit_err), 32'd1);
      cyc(6'h00, 6'h00, 1'b0, 1'b0);
      cyc(6'h01, 6'h01, 1'b0, 1'b0);
      chk("ovf_sticky", 32'(credit_err), 32'd1);
      cyc(6'h00, 6'h00, 1'b0, 1'b1);
      chk("ovf_clear", 32'(credit_err), 32'd0);
`endif
      cyc(6'h00, 6'h00, 1'b0, 1'b0);
      cyc(6'h00, 6'h00, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
